// File: rtl/cpu_pkg.sv
// Shared CPU/loader definitions: memory geometry and the loader state encoding.
package cpu_pkg;
    localparam int WIDTH    = 32;
    localparam int ADDRSIZE = 12;
    localparam int MEMSIZE  = 2 ** ADDRSIZE;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        CHK,
        DONE,
        ERR
    } ld_state_e;
endpackage

// File: rtl/byte_packer.sv
// Packs a big-endian byte stream into WIDTH-bit words; the completed word is
// presented combinationally alongside the byte that finishes it.
module byte_packer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid_o
);
    localparam int BPW = WIDTH / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-9:0] acc_q;
    logic             last_byte;

    assign last_byte    = (cnt_q == CW'(BPW - 1));
    assign word_o       = {acc_q, byte_i};
    assign word_valid_o = byte_valid_i && last_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q <= last_byte ? '0 : cnt_q + CW'(1);
            acc_q <= word_o[WIDTH-9:0];
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a counted, checksummed byte frame, writes it to memory
// from address 0, and holds the CPU in reset until the image is verified.
module prog_loader #(
    parameter int WIDTH    = cpu_pkg::WIDTH,
    parameter int ADDRSIZE = cpu_pkg::ADDRSIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                mem_we,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    output logic                cpu_rst,
    output logic                done,
    output logic                err
);
    import cpu_pkg::*;

    ld_state_e           state_q;
    logic [7:0]          hdr_q;
    logic [7:0]          chk_q;
    logic [ADDRSIZE-1:0] word_cnt_q;
    logic [ADDRSIZE-1:0] last_q;
    logic                mem_we_q;
    logic [WIDTH-1:0]    mem_wdata_q;
    logic                cpu_rst_q;
    logic                done_q;
    logic                err_q;

    logic             accept;
    logic [16:0]      n_w;
    logic             n_ok;
    logic [WIDTH-1:0] word;
    logic             word_valid;

    assign in_ready = (state_q == HDR_HI || state_q == HDR_LO ||
                       state_q == DATA   || state_q == CHK) && !start;
    assign accept   = in_valid && in_ready;

    assign n_w  = {1'b0, hdr_q, in_data};
    assign n_ok = (n_w != 17'd0) && (n_w <= (17'd1 << ADDRSIZE));

    byte_packer #(.WIDTH(WIDTH)) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (start),
        .byte_valid_i(accept && state_q == DATA),
        .byte_i      (in_data),
        .word_o      (word),
        .word_valid_o(word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hdr_q       <= '0;
            chk_q       <= '0;
            word_cnt_q  <= '0;
            last_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (start && state_q != IDLE) begin
                state_q    <= HDR_HI;
                chk_q      <= '0;
                word_cnt_q <= '0;
                cpu_rst_q  <= 1'b1;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
            end else begin
                // Address advances during the write cycle so it stays stable
                // while mem_we is high, and parks on N-1 after the last word.
                if (mem_we_q && word_cnt_q != last_q)
                    word_cnt_q <= word_cnt_q + ADDRSIZE'(1);
                case (state_q)
                    IDLE: state_q <= HDR_HI;
                    HDR_HI: if (accept) begin
                        hdr_q   <= in_data;
                        state_q <= HDR_LO;
                    end
                    HDR_LO: if (accept) begin
                        if (n_ok) begin
                            last_q  <= ADDRSIZE'(n_w - 17'd1);
                            state_q <= DATA;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ERR;
                        end
                    end
                    DATA: if (accept) begin
                        chk_q <= chk_q ^ in_data;
                        if (word_valid) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= word;
                            if (word_cnt_q == last_q) state_q <= CHK;
                        end
                    end
                    CHK: if (accept) begin
                        if (in_data == chk_q) begin
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                            state_q   <= DONE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ERR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = word_cnt_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives frames byte by byte and checks memory
// writes, status outputs and handshake behaviour against hand-computed values.
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:4095];
    int          wr_cnt = 0;
    logic [11:0] last_addr = '0;
    logic [31:0] last_data = '0;
    logic        prev_we = 1'b0;
    logic        we_twice = 1'b0;

    prog_loader #(.WIDTH(32), .ADDRSIZE(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Memory model: each write cycle spans a full period, so the falling edge sees it once.
    always @(negedge clk) begin
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt        = wr_cnt + 1;
            last_addr     = mem_addr;
            last_data     = mem_wdata;
        end
        if (mem_we && prev_we) we_twice = 1'b1;
        prev_we = mem_we;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        for (int g = 0; g < gap; g++) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_byte timeout: in_ready=%b wanted 1 (byte %h)", in_ready, b);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_frame1(input logic [7:0] chk, input int maxgap);
        logic [7:0] d [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        send_byte(8'h00, $urandom_range(0, maxgap));
        send_byte(8'h02, $urandom_range(0, maxgap));
        for (int i = 0; i < 8; i++) send_byte(d[i], $urandom_range(0, maxgap));
        send_byte(chk, $urandom_range(0, maxgap));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++; if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 12'h0 || mem_wdata !== 32'h0)
            begin fails++; $display("FAIL reset_data: rdy=%b we=%b addr=%h wd=%h wanted 0 0 000 00000000", in_ready, mem_we, mem_addr, mem_wdata); end
        tests++; if (cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0)
            begin fails++; $display("FAIL reset_status: cpu_rst=%b done=%b err=%b wanted 1 0 0", cpu_rst, done, err); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL idle_not_ready: in_ready=%b wanted 0", in_ready); end
        @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL hdr_hi_ready: in_ready=%b wanted 1", in_ready); end
    endtask

    task automatic test_good_frame();
        int base = wr_cnt;
        send_frame1(8'h00, 0);
        tests++; if (done !== 1'b1 || cpu_rst !== 1'b0 || err !== 1'b0)
            begin fails++; $display("FAIL good_status: done=%b cpu_rst=%b err=%b wanted 1 0 0", done, cpu_rst, err); end
        tests++; if (wr_cnt - base != 2) begin fails++; $display("FAIL good_writes: got %0d wanted 2", wr_cnt - base); end
        tests++; if (mem[0] !== 32'h12345678 || mem[1] !== 32'h9ABCDEF0)
            begin fails++; $display("FAIL good_mem: mem0=%h mem1=%h wanted 12345678 9abcdef0", mem[0], mem[1]); end
        @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL done_not_ready: in_ready=%b wanted 0", in_ready); end
    endtask

    task automatic test_bad_checksum();
        int base;
        pulse_start();
        tests++; if (done !== 1'b0 || cpu_rst !== 1'b1) begin fails++; $display("FAIL start_clears: done=%b cpu_rst=%b wanted 0 1", done, cpu_rst); end
        mem[0] = 32'h0; mem[1] = 32'h0;
        base = wr_cnt;
        send_frame1(8'h01, 0);
        tests++; if (err !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0)
            begin fails++; $display("FAIL badchk_status: err=%b cpu_rst=%b done=%b wanted 1 1 0", err, cpu_rst, done); end
        tests++; if (wr_cnt - base != 2 || mem[1] !== 32'h9ABCDEF0)
            begin fails++; $display("FAIL badchk_writes: n=%0d mem1=%h wanted 2 9abcdef0", wr_cnt - base, mem[1]); end
        @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL err_not_ready: in_ready=%b wanted 0", in_ready); end
        pulse_start();
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL start_clears_err: err=%b wanted 0", err); end
        send_frame1(8'h00, 0);
        tests++; if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL reload_status: done=%b err=%b wanted 1 0", done, err); end
    endtask

    task automatic test_bad_header();
        int base;
        pulse_start();
        base = wr_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        tests++; if (err !== 1'b1 || wr_cnt != base) begin fails++; $display("FAIL hdr_zero: err=%b writes=%0d wanted 1 0", err, wr_cnt - base); end
        pulse_start();
        send_byte(8'h10, 0);
        send_byte(8'h01, 0);
        tests++; if (err !== 1'b1 || wr_cnt != base) begin fails++; $display("FAIL hdr_4097: err=%b writes=%0d wanted 1 0", err, wr_cnt - base); end
        @(negedge clk);
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL hdr_no_we: mem_we=%b wanted 0", mem_we); end
    endtask

    task automatic test_full_image();
        int base;
        logic [7:0]  x = 8'h00;
        logic [31:0] w;
        pulse_start();
        base = wr_cnt;
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL hdr_4096: err=%b wanted 0", err); end
        for (int i = 0; i < 4096; i++) begin
            w = i;
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31-8*b -: 8], 0);
                x = x ^ w[31-8*b -: 8];
            end
        end
        send_byte(x, 0);
        tests++; if (wr_cnt - base != 4096) begin fails++; $display("FAIL full_writes: got %0d wanted 4096", wr_cnt - base); end
        tests++; if (last_addr !== 12'hFFF || last_data !== 32'h00000FFF)
            begin fails++; $display("FAIL full_last: addr=%h data=%h wanted fff 00000fff", last_addr, last_data); end
        tests++; if (mem[100] !== 32'd100 || mem[2049] !== 32'd2049)
            begin fails++; $display("FAIL full_mem: m100=%h m2049=%h wanted 00000064 00000801", mem[100], mem[2049]); end
        tests++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin fails++; $display("FAIL full_done: done=%b cpu_rst=%b wanted 1 0", done, cpu_rst); end
    endtask

    task automatic test_gaps();
        int base;
        pulse_start();
        mem[0] = 32'h0; mem[1] = 32'h0;
        base = wr_cnt;
        send_frame1(8'h00, 4);
        tests++; if (wr_cnt - base != 2 || mem[0] !== 32'h12345678 || mem[1] !== 32'h9ABCDEF0)
            begin fails++; $display("FAIL gaps_mem: n=%0d mem0=%h mem1=%h wanted 2 12345678 9abcdef0", wr_cnt - base, mem[0], mem[1]); end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL gaps_done: done=%b wanted 1", done); end
    endtask

    task automatic test_abort();
        int base;
        logic [7:0] d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        pulse_start();
        base = wr_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int i = 0; i < 5; i++) send_byte(d[i], 0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h66; start = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL abort_blocks: in_ready=%b wanted 0", in_ready); end
        @(posedge clk);
        #1 start = 1'b0; in_valid = 1'b0;
        repeat (6) @(negedge clk);
        tests++; if (wr_cnt - base != 1 || mem[0] !== 32'h11223344)
            begin fails++; $display("FAIL abort_writes: n=%0d mem0=%h wanted 1 11223344", wr_cnt - base, mem[0]); end
        tests++; if (in_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || cpu_rst !== 1'b1)
            begin fails++; $display("FAIL abort_state: rdy=%b done=%b err=%b cpu_rst=%b wanted 1 0 0 1", in_ready, done, err, cpu_rst); end
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hCA, 0); send_byte(8'hFE, 0); send_byte(8'hF0, 0); send_byte(8'h0D, 0);
        send_byte(8'hC9, 0);
        tests++; if (mem[0] !== 32'hCAFEF00D || done !== 1'b1)
            begin fails++; $display("FAIL abort_reload: mem0=%h done=%b wanted cafef00d 1", mem[0], done); end
    endtask

    task automatic test_mid_reset();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 0);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (mem_we !== 1'b0 || mem_addr !== 12'h0 || mem_wdata !== 32'h0 || in_ready !== 1'b0)
            begin fails++; $display("FAIL midrst_data: we=%b addr=%h wd=%h rdy=%b wanted 0 000 00000000 0", mem_we, mem_addr, mem_wdata, in_ready); end
        tests++; if (cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0)
            begin fails++; $display("FAIL midrst_status: cpu_rst=%b done=%b err=%b wanted 1 0 0", cpu_rst, done, err); end
        test_reset();
        send_frame1(8'h00, 0);
        tests++; if (done !== 1'b1 || mem[1] !== 32'h9ABCDEF0)
            begin fails++; $display("FAIL midrst_reload: done=%b mem1=%h wanted 1 9abcdef0", done, mem[1]); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_header();
        test_full_image();
        test_gaps();
        test_abort();
        test_mid_reset();
        tests++; if (we_twice) begin fails++; $display("FAIL we_spacing: consecutive mem_we=%b wanted 0", we_twice); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that receives a byte stream from a host link, packs it into 32-bit instruction words, and writes them into the CPU's instruction/data memory starting at address 0. It holds the CPU in reset until a complete, checksum-verified image has been written. It then releases the CPU so fetch begins at pc = 0. It is the writer side of the memory the CPU fetch stage reads.

## Interface
Parameters:
- WIDTH, 32, memory word width; must be a multiple of 8.
- ADDRSIZE, 12, memory address width; maximum image is 2^ADDRSIZE words.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse. Aborts any load in progress and re-arms for a new frame.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader accepts the byte. A byte transfers on a clock edge where in_valid && in_ready.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDRSIZE  word address of the write.
- mem_wdata  out  WIDTH  word written.
- cpu_rst  out  1  active-high CPU reset. Asserted except in DONE.
- done  out  1  image loaded and verified.
- err  out  1  frame rejected; sticky until start or rst_n.

## Operation
- Frame format, all big-endian:
  - 2 header bytes: word count N.
  - N×WIDTH/8 data bytes.
  - 1 checksum byte: XOR of all data bytes. Header bytes are not included.
- Valid N is 1..2^ADDRSIZE. N = 0 or N > 2^ADDRSIZE goes to ERR.
- States and transitions:
  - IDLE → HDR_HI, unconditionally on the first edge after reset.
  - HDR_HI → HDR_LO on byte accept.
  - HDR_LO → DATA on byte accept when N is valid; → ERR when N is invalid.
  - DATA → CHK after the last data byte is accepted.
  - CHK → DONE on byte accept when the checksum matches; → ERR on mismatch.
  - DONE and ERR hold until start.
- in_ready = (state ∈ {HDR_HI, HDR_LO, DATA, CHK}) && !start.
- start has priority over a simultaneous byte. From any state other than IDLE, start goes to HDR_HI and clears:
  - byte counter, word counter, checksum accumulator;
  - done and err.
  - cpu_rst is set to 1.
- Word packing: the first byte of each word lands in bits [WIDTH-1:WIDTH-8].
- Word counter runs 0..N-1 and drives mem_addr. It does not wrap within a frame; the last address written is N-1.
- The checksum accumulator XORs every accepted DATA byte.
- No writes occur in ERR. Words already written before an error stay in memory. cpu_rst stays 1.

## Timing
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rst 1, done 0, err 0. Reset takes effect immediately, including mid-frame.
- Write latency: if the last byte of a word is accepted at edge k, then mem_we = 1 with mem_addr/mem_wdata valid for the cycle after edge k, and the memory captures the word at edge k+1.
- mem_we is never high for two consecutive cycles (WIDTH ≥ 16 guarantees byte spacing).
- Checksum accepted at edge k: from edge k, done = 1 and cpu_rst = 0 (or err = 1 on mismatch).
  - The last mem_we precedes the cpu_rst release by at least one cycle.
- err asserts on the edge that accepts the offending byte (second header byte or checksum byte).
- in_valid gaps of any length are allowed. State holds while no handshake occurs.
- All outputs are registered except in_ready.

## Structure
- Shared package cpu_pkg holds WIDTH, ADDRSIZE and MEMSIZE, shared with the CPU model, plus the loader state enum (IDLE, HDR_HI, HDR_LO, DATA, CHK, DONE, ERR).
- One sub-module: byte_packer, which takes bytes and a clear input and outputs a word and word_valid.
- prog_loader keeps the FSM, counters, checksum and output registers.

## Test plan
- N = 2 with data 12 34 56 78 9A BC DE F0 and checksum 00 → MEM[0] = 0x12345678, MEM[1] = 0x9ABCDEF0. done = 1 and cpu_rst = 0 on the checksum edge; in_ready = 0 afterwards.
- Same frame with checksum 01 → both words written, err = 1, cpu_rst = 1, done = 0, in_ready = 0. A later start plus a good frame gives done = 1.
- Header 00 00 → err on the second header byte with no mem_we. Header 10 01 (4097) → err.
- N = 4096 with data word i = i → 4096 writes, last mem_addr = 0xFFF with mem_wdata = 0x00000FFF, then done.
- Random in_valid gaps on the frame from scenario 1 → identical writes and result. start asserted after 5 data bytes, together with in_valid → that byte is not accepted, no further mem_we occurs, state returns to HDR_HI, and the next frame loads correctly.
- rst_n pulled low mid-DATA → all outputs at reset values before the next edge. After release, the first header byte is accepted only from HDR_HI (one cycle after IDLE).
